// File: rtl/spi_dual_rx.sv
// Dual-lane SPI slave receiver: oversamples CS/SCK/MOSI, deserializes two MSB-first lanes.
// Optional echo of the previous frame on spi_miso_o when SPI_DUAL_RX_ECHO_EN is defined.
module spi_dual_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_ni,
    input  logic              en_i,
    input  logic              spi_cs_ni,
    input  logic              spi_sck_i,
    input  logic [1:0]        spi_mosi_i,
    output logic [1:0]        spi_miso_o,
    output logic [DATA_W-1:0] data0_o,
    output logic [DATA_W-1:0] data1_o,
    output logic              data_update_o,
    output logic              frame_err_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FULL  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t                       r_state;
    logic [SYNC_STAGES-1:0]       r_cs_sync;
    logic [SYNC_STAGES-1:0]       r_sck_sync;
    logic [SYNC_STAGES-1:0][1:0]  r_mosi_sync;
    logic                         r_cs_prev;
    logic                         r_sck_prev;
    logic [CW-1:0]                r_bit_cnt;
    logic [DATA_W-1:0]            r_sh0;
    logic [DATA_W-1:0]            r_sh1;

    logic              w_cs_s;
    logic              w_sck_s;
    logic [1:0]        w_mosi_s;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_sck_rise;
    logic [CW-1:0]     w_cnt_inc;
    logic [DATA_W-1:0] w_sh0_next;
    logic [DATA_W-1:0] w_sh1_next;

    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_prev & ~w_cs_s;
    assign w_cs_rise  = ~r_cs_prev & w_cs_s;
    assign w_sck_rise = ~r_sck_prev & w_sck_s;
    assign w_cnt_inc  = r_bit_cnt + CW'(1);
    assign w_sh0_next = {r_sh0[DATA_W-2:0], w_mosi_s[0]};
    assign w_sh1_next = {r_sh1[DATA_W-2:0], w_mosi_s[1]};

    // Input synchronizers plus one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b1;
            r_sck_prev  <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            r_cs_prev   <= w_cs_s;
            r_sck_prev  <= w_sck_s;
        end
    end

    // Frame FSM; a shift coinciding with cs_rise is counted before the frame is judged
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_sh0         <= '0;
            r_sh1         <= '0;
            data0_o       <= '0;
            data1_o       <= '0;
            data_update_o <= 1'b0;
            frame_err_o   <= 1'b0;
            frame_cnt_o   <= 16'd0;
        end else begin
            data_update_o <= 1'b0;
            frame_err_o   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall && en_i) begin
                        r_state   <= S_SHIFT;
                        r_bit_cnt <= '0;
                        r_sh0     <= '0;
                        r_sh1     <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_sck_rise) begin
                        r_sh0     <= w_sh0_next;
                        r_sh1     <= w_sh1_next;
                        r_bit_cnt <= w_cnt_inc;
                    end
                    if (w_cs_rise) begin
                        r_state <= S_IDLE;
                        if (w_sck_rise && (w_cnt_inc == LAST_CNT)) begin
                            data0_o       <= w_sh0_next;
                            data1_o       <= w_sh1_next;
                            data_update_o <= 1'b1;
                            frame_cnt_o   <= frame_cnt_o + 16'd1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else if (w_sck_rise && (w_cnt_inc == LAST_CNT)) begin
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_cs_rise) begin
                        r_state <= S_IDLE;
                        if (w_sck_rise) begin
                            frame_err_o <= 1'b1;
                        end else begin
                            data0_o       <= r_sh0;
                            data1_o       <= r_sh1;
                            data_update_o <= 1'b1;
                            frame_cnt_o   <= frame_cnt_o + 16'd1;
                        end
                    end else if (w_sck_rise) begin
                        r_state <= S_ERR;
                    end
                end
                S_ERR: begin
                    if (w_cs_rise) begin
                        r_state     <= S_IDLE;
                        frame_err_o <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_DUAL_RX_ECHO_EN
    logic [DATA_W-1:0] r_echo0;
    logic [DATA_W-1:0] r_echo1;
    logic [1:0]        r_miso;
    logic              w_sck_fall;

    assign w_sck_fall = r_sck_prev & ~w_sck_s;

    // Echo shifter: register holds the bits still to be sent after the one on the pins
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            r_echo0 <= '0;
            r_echo1 <= '0;
            r_miso  <= 2'b00;
        end else if (r_state == S_IDLE) begin
            if (w_cs_fall && en_i) begin
                r_echo0 <= {data0_o[DATA_W-2:0], 1'b0};
                r_echo1 <= {data1_o[DATA_W-2:0], 1'b0};
                r_miso  <= {data1_o[DATA_W-1], data0_o[DATA_W-1]};
            end else begin
                r_miso  <= 2'b00;
            end
        end else if (w_cs_rise) begin
            r_miso <= 2'b00;
        end else if (w_sck_fall) begin
            r_miso  <= {r_echo1[DATA_W-1], r_echo0[DATA_W-1]};
            r_echo0 <= {r_echo0[DATA_W-2:0], 1'b0};
            r_echo1 <= {r_echo1[DATA_W-2:0], 1'b0};
        end
    end

    assign spi_miso_o = r_miso;
`else
    assign spi_miso_o = 2'b00;
`endif

endmodule

// File: tb/tb_spi_dual_rx.sv
// Self-checking bench for spi_dual_rx: scoreboard of expected commits vs observed update pulses.
module tb_spi_dual_rx;
    localparam int DW = 16;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        spi_cs_ni = 1'b1;
    logic        spi_sck_i = 1'b0;
    logic [1:0]  spi_mosi_i = 2'b00;
    logic [1:0]  spi_miso_o;
    logic [DW-1:0] data0_o, data1_o;
    logic        data_update_o, frame_err_o;
    logic [15:0] frame_cnt_o;

    spi_dual_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_ni(reset_ni), .en_i(en_i),
        .spi_cs_ni(spi_cs_ni), .spi_sck_i(spi_sck_i), .spi_mosi_i(spi_mosi_i),
        .spi_miso_o(spi_miso_o), .data0_o(data0_o), .data1_o(data1_o),
        .data_update_o(data_update_o), .frame_err_o(frame_err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] cnt;
    } upd_t;

    upd_t exp_q[$];
    upd_t obs_q[$];
    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int both_high = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [15:0] cap0, cap1;

    // Monitor: record every update and error pulse
    always @(negedge clk) begin
        if (data_update_o) obs_q.push_back({data0_o, data1_o, frame_cnt_o});
        if (frame_err_o) err_seen++;
        if (data_update_o && frame_err_o) both_high++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_bits(input logic [15:0] w0, input logic [15:0] w1, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = (i < DW) ? (DW - 1 - i) : 0;
            spi_mosi_i = {w1[b], w0[b]};
            clks(4);
            if (i < DW) begin
                cap0 = {cap0[14:0], spi_miso_o[0]};
                cap1 = {cap1[14:0], spi_miso_o[1]};
            end
            spi_sck_i = 1'b1;
            clks(4);
            spi_sck_i = 1'b0;
        end
        clks(4);
    endtask

    task automatic send(input logic [15:0] w0, input logic [15:0] w1, input int nbits);
        spi_cs_ni = 1'b0;
        clks(4);
        frame_bits(w0, w1, nbits);
        spi_cs_ni = 1'b1;
        clks(10);
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        clks(3);
        checks++; if (data0_o !== 16'd0) begin failures++; $display("FAIL reset_data0 got=%h exp=0000", data0_o); end
        checks++; if (data1_o !== 16'd0) begin failures++; $display("FAIL reset_data1 got=%h exp=0000", data1_o); end
        checks++; if (frame_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", frame_cnt_o); end
        checks++; if ({spi_miso_o, data_update_o, frame_err_o} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {spi_miso_o, data_update_o, frame_err_o});
        end
        reset_ni = 1'b1;
        clks(4);
    endtask

    task automatic test_basic();
        int e0;
        upd_t o, e;
        e0 = err_seen;
        en_i = 1'b1;
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back({16'h0828, 16'h0833, exp_cnt});
        spi_cs_ni = 1'b0;
        clks(4);
        frame_bits(16'h0828, 16'h0833, DW);
        spi_cs_ni = 1'b1;
        for (int k = 1; k <= SS + 2; k++) begin
            @(negedge clk);
            checks++;
            if (data_update_o !== (k == SS + 1)) begin
                failures++; $display("FAIL basic_latency edge=%0d got=%b exp=%b", k, data_update_o, (k == SS + 1));
            end
        end
        clks(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL basic_update got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL basic_update got=%h exp=%h", o, e); end end
        end
        checks++; if (err_seen != e0) begin failures++; $display("FAIL basic_err got=%0d exp=0", err_seen - e0); end
    endtask

    task automatic test_abort();
        int e0;
        e0 = err_seen;
        send(16'hFFFF, 16'hFFFF, 9);
        checks++; if (err_seen - e0 != 1) begin failures++; $display("FAIL abort_err got=%0d exp=1", err_seen - e0); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL abort_update got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        checks++; if ({data0_o, data1_o, frame_cnt_o} !== {16'h0828, 16'h0833, exp_cnt}) begin
            failures++; $display("FAIL abort_hold got=%h %h %h exp=0828 0833 %h", data0_o, data1_o, frame_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_overrun();
        int e0;
        upd_t o, e;
        e0 = err_seen;
        send(16'h5A5A, 16'hA5A5, DW + 1);
        checks++; if (err_seen - e0 != 1) begin failures++; $display("FAIL overrun_err got=%0d exp=1", err_seen - e0); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL overrun_update got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back({16'hABCD, 16'h1234, exp_cnt});
        send(16'hABCD, 16'h1234, DW);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL overrun_next got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL overrun_next got=%h exp=%h", o, e); end end
        end
    endtask

    task automatic test_enable();
        int e0;
        upd_t o, e;
        e0 = err_seen;
        en_i = 1'b0;
        send(16'h1357, 16'h2468, DW);
        checks++; if (obs_q.size() != 0 || err_seen != e0) begin
            failures++; $display("FAIL en_low got=upd%0d err%0d exp=upd0 err0", obs_q.size(), err_seen - e0); obs_q.delete();
        end
        // en_i dropping after cs_fall must not affect the frame
        en_i = 1'b1;
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back({16'h1357, 16'h2468, exp_cnt});
        spi_cs_ni = 1'b0;
        clks(4);
        en_i = 1'b0;
        frame_bits(16'h1357, 16'h2468, DW);
        spi_cs_ni = 1'b1;
        clks(10);
        en_i = 1'b1;
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back({16'hC3C3, 16'h3C3C, exp_cnt});
        send(16'hC3C3, 16'h3C3C, DW);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL en_high got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL en_high got=%h exp=%h", o, e); end end
        end
        checks++; if (err_seen != e0) begin failures++; $display("FAIL en_err got=%0d exp=0", err_seen - e0); end
    endtask

    task automatic test_mid_reset();
        int e0;
        upd_t o, e;
        e0 = err_seen;
        spi_cs_ni = 1'b0;
        clks(4);
        frame_bits(16'hFFFF, 16'hFFFF, 5);
        reset_ni = 1'b0;
        clks(2);
        spi_cs_ni = 1'b1;
        clks(4);
        reset_ni = 1'b1;
        clks(8);
        exp_cnt = 16'd0;
        checks++; if (obs_q.size() != 0 || err_seen != e0) begin
            failures++; $display("FAIL midrst_pulse got=upd%0d err%0d exp=upd0 err0", obs_q.size(), err_seen - e0); obs_q.delete();
        end
        checks++; if ({data0_o, frame_cnt_o} !== 32'd0) begin
            failures++; $display("FAIL midrst_clear got=%h %h exp=0000 0000", data0_o, frame_cnt_o);
        end
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back({16'h0F0F, 16'hF0F0, exp_cnt});
        send(16'h0F0F, 16'hF0F0, DW);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL midrst_idle got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL midrst_idle got=%h exp=%h", o, e); end end
        end
    endtask

    task automatic test_wrap();
        upd_t o, e;
        force dut.frame_cnt_o = 16'hFFFF;
        clks(1);
        release dut.frame_cnt_o;
        clks(1);
        exp_cnt = 16'hFFFF + 16'd1;
        exp_q.push_back({16'h1111, 16'h2222, exp_cnt});
        send(16'h1111, 16'h2222, DW);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL wrap got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL wrap got=%h exp=%h", o, e); end end
        end
    endtask

    task automatic test_echo();
        logic [15:0] x0, x1;
        upd_t o, e;
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back({16'h0828, 16'h0833, exp_cnt});
        send(16'h0828, 16'h0833, DW);
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back({16'h5555, 16'hAAAA, exp_cnt});
        cap0 = 16'hDEAD;
        cap1 = 16'hBEEF;
        send(16'h5555, 16'hAAAA, DW);
`ifdef SPI_DUAL_RX_ECHO_EN
        x0 = 16'h0828;
        x1 = 16'h0833;
`else
        x0 = 16'h0000;
        x1 = 16'h0000;
`endif
        checks++; if (cap0 !== x0) begin failures++; $display("FAIL echo_lane0 got=%h exp=%h", cap0, x0); end
        checks++; if (cap1 !== x1) begin failures++; $display("FAIL echo_lane1 got=%h exp=%h", cap1, x1); end
        checks++; if (spi_miso_o !== 2'b00) begin failures++; $display("FAIL echo_idle got=%b exp=00", spi_miso_o); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL echo_update got=none exp=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL echo_update got=%h exp=%h", o, e); end end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_overrun();
        test_enable();
        test_mid_reset();
        test_wrap();
        test_echo();
        checks++; if (both_high != 0) begin failures++; $display("FAIL exclusive_pulses got=%0d exp=0", both_high); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL stray_updates got=%0d exp=0", obs_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
